// File: rtl/inst_cache_pkg.sv
// Shared types, constants and address-field helpers for the direct-mapped instruction cache.
package inst_cache_pkg;

  localparam int unsigned DEF_NUM_LINES  = 32;
  localparam int unsigned DEF_LINE_WORDS = 4;
  localparam logic [31:0] NOP_INSTR      = 32'h0000_0013;

  localparam int unsigned OFF_W = $clog2(DEF_LINE_WORDS);
  localparam int unsigned IDX_W = $clog2(DEF_NUM_LINES);
  localparam int unsigned TAG_W = 30 - OFF_W - IDX_W;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_REFILL = 1'b1
  } state_e;

  // Byte address layout: {tag, index, offset, 2'b00}.
  function automatic int unsigned off_lsb();
    return 2;
  endfunction

  function automatic int unsigned idx_lsb(input int unsigned off_w);
    return 2 + off_w;
  endfunction

  function automatic int unsigned tag_lsb(input int unsigned off_w, input int unsigned idx_w);
    return 2 + off_w + idx_w;
  endfunction

  function automatic logic [31:0] line_base(input logic [31:0] pc, input int unsigned off_w);
    return pc & ~((32'd1 << (off_w + 2)) - 32'd1);
  endfunction

endpackage

// File: rtl/inst_cache_array.sv
// Valid/tag/data storage for the instruction cache: combinational read, beat write, line validate, flush-all.
module inst_cache_array
  import inst_cache_pkg::*;
#(
  parameter int unsigned NUM_LINES  = DEF_NUM_LINES,
  parameter int unsigned LINE_WORDS = DEF_LINE_WORDS,
  parameter int unsigned OFF_BITS   = $clog2(LINE_WORDS),
  parameter int unsigned IDX_BITS   = $clog2(NUM_LINES),
  parameter int unsigned TAG_BITS   = 30 - OFF_BITS - IDX_BITS
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [IDX_BITS-1:0] rd_idx_i,
  input  logic [OFF_BITS-1:0] rd_off_i,
  output logic [31:0]         rd_word_o,
  output logic [TAG_BITS-1:0] rd_tag_o,
  output logic                rd_valid_o,
  input  logic                wr_en_i,
  input  logic [IDX_BITS-1:0] wr_idx_i,
  input  logic [OFF_BITS-1:0] wr_off_i,
  input  logic [31:0]         wr_data_i,
  input  logic                val_en_i,
  input  logic [IDX_BITS-1:0] val_idx_i,
  input  logic [TAG_BITS-1:0] val_tag_i,
  input  logic                flush_i
);

  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_BITS-1:0]  tag_q  [NUM_LINES];
  logic [31:0]          data_q [NUM_LINES][LINE_WORDS];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
    end else if (flush_i) begin
      valid_q <= '0;
    end else if (val_en_i) begin
      valid_q[val_idx_i] <= 1'b1;
    end
  end

  // NOTE: tag and data arrays carry no reset; the valid bits alone decide whether their contents are used.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      data_q[wr_idx_i][wr_off_i] <= wr_data_i;
    end
    if (val_en_i) begin
      tag_q[val_idx_i] <= val_tag_i;
    end
  end

  assign rd_word_o  = data_q[rd_idx_i][rd_off_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_valid_o = valid_q[rd_idx_i];

endmodule

// File: rtl/inst_cache_sys.sv
// Direct-mapped read-only instruction cache: same-cycle hits, stalled beat-wise line refill on a miss.
module inst_cache_sys
  import inst_cache_pkg::*;
#(
  parameter int unsigned NUM_LINES  = DEF_NUM_LINES,
  parameter int unsigned LINE_WORDS = DEF_LINE_WORDS,
  parameter logic [31:0] NOP_WORD   = NOP_INSTR
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] PC,
  input  logic        Flush,
  output logic [31:0] Instr,
  output logic        Stall,
  output logic        MemReq,
  output logic [31:0] MemAddr,
  input  logic        MemValid,
  input  logic [31:0] MemData
);

  localparam int unsigned OFF_BITS = $clog2(LINE_WORDS);
  localparam int unsigned IDX_BITS = $clog2(NUM_LINES);
  localparam int unsigned OFF_LSB  = off_lsb();
  localparam int unsigned IDX_LSB  = idx_lsb(OFF_BITS);
  localparam int unsigned TAG_LSB  = tag_lsb(OFF_BITS, IDX_BITS);
  localparam int unsigned TAG_BITS = 32 - TAG_LSB;

  localparam logic [OFF_BITS-1:0] LAST_BEAT = OFF_BITS'(LINE_WORDS - 1);
  localparam logic [OFF_BITS-1:0] BEAT_ONE  = OFF_BITS'(1);

  state_e              state_q;
  logic [OFF_BITS-1:0] beat_q;
  logic [31:0]         addr_q;
  logic                flush_pend_q;

  logic [OFF_BITS-1:0] pc_off;
  logic [IDX_BITS-1:0] pc_idx;
  logic [TAG_BITS-1:0] pc_tag;
  logic [IDX_BITS-1:0] fill_idx;
  logic [TAG_BITS-1:0] fill_tag;
  logic                unused_pc_bits;

  logic [31:0]         rd_word;
  logic [TAG_BITS-1:0] rd_tag;
  logic                rd_valid;
  logic                hit;
  logic                refilling;
  logic                beat_accept;
  logic                last_beat;
  logic                val_en;

  assign pc_off         = PC[OFF_LSB +: OFF_BITS];
  assign pc_idx         = PC[IDX_LSB +: IDX_BITS];
  assign pc_tag         = PC[TAG_LSB +: TAG_BITS];
  assign unused_pc_bits = ^PC[OFF_LSB-1:0];

  // The refill targets the latched line, never the live PC.
  assign fill_idx = addr_q[IDX_LSB +: IDX_BITS];
  assign fill_tag = addr_q[TAG_LSB +: TAG_BITS];

  assign refilling   = (state_q == ST_REFILL);
  assign beat_accept = refilling && MemValid;
  assign last_beat   = (beat_q == LAST_BEAT);
  assign val_en      = beat_accept && last_beat && !flush_pend_q && !Flush;

  inst_cache_array #(
    .NUM_LINES (NUM_LINES),
    .LINE_WORDS(LINE_WORDS),
    .OFF_BITS  (OFF_BITS),
    .IDX_BITS  (IDX_BITS),
    .TAG_BITS  (TAG_BITS)
  ) u_array (
    .clk_i     (CLK),
    .rst_i     (RST),
    .rd_idx_i  (pc_idx),
    .rd_off_i  (pc_off),
    .rd_word_o (rd_word),
    .rd_tag_o  (rd_tag),
    .rd_valid_o(rd_valid),
    .wr_en_i   (beat_accept),
    .wr_idx_i  (fill_idx),
    .wr_off_i  (beat_q),
    .wr_data_i (MemData),
    .val_en_i  (val_en),
    .val_idx_i (fill_idx),
    .val_tag_i (fill_tag),
    .flush_i   (Flush)
  );

  assign hit = rd_valid && (rd_tag == pc_tag);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      beat_q       <= '0;
      addr_q       <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!hit) begin
            state_q <= ST_REFILL;
            addr_q  <= line_base(PC, OFF_BITS);
          end
        end
        ST_REFILL: begin
          if (Flush) begin
            flush_pend_q <= 1'b1;
          end
          if (MemValid) begin
            if (last_beat) begin
              state_q      <= ST_IDLE;
              beat_q       <= '0;
              flush_pend_q <= 1'b0;
            end else begin
              beat_q <= beat_q + BEAT_ONE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign Stall   = refilling || !hit;
  assign Instr   = Stall ? NOP_WORD : rd_word;
  assign MemReq  = refilling;
  assign MemAddr = addr_q;

endmodule

// File: tb/tb_inst_cache_sys.sv
// Directed bench for inst_cache_sys: a memory responder feeds refills, a monitor scores fetched instructions.
module tb_inst_cache_sys;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        CLK;
  logic        RST;
  logic [31:0] PC;
  logic        Flush;
  logic [31:0] Instr;
  logic        Stall;
  logic        MemReq;
  logic [31:0] MemAddr;
  logic        MemValid;
  logic [31:0] MemData;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] exp_addr;
  int          n_tests;
  int          n_fail;
  int          refill_cnt;
  bit          mon_en;
  bit          spur_en;
  int          gap_budget;
  int          beat_limit;

  inst_cache_sys dut (
    .CLK     (CLK),
    .RST     (RST),
    .PC      (PC),
    .Flush   (Flush),
    .Instr   (Instr),
    .Stall   (Stall),
    .MemReq  (MemReq),
    .MemAddr (MemAddr),
    .MemValid(MemValid),
    .MemData (MemData)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0050_0093;
      32'h0000_0004: return 32'h0060_0113;
      32'h0000_0008: return 32'h0020_81B3;
      32'h0000_000C: return 32'h0000_0013;
      32'h0000_0200: return 32'hAAAA_0001;
      32'h0000_0204: return 32'hAAAA_0002;
      32'h0000_0208: return 32'hAAAA_0003;
      32'h0000_020C: return 32'hAAAA_0004;
      default:       return 32'h0000_0000;
    endcase
  endfunction

  // Backing memory: one beat per cycle while MemReq, optional single-cycle gaps before beats 1..gap_budget.
  initial begin
    int  rbeat;
    bit  gapped;
    rbeat    = 0;
    gapped   = 1'b0;
    MemValid = 1'b0;
    MemData  = 32'h0;
    forever begin
      @(posedge CLK);
      #1;
      if (MemValid) begin
        rbeat++;
        gapped = 1'b0;
      end
      MemValid = 1'b0;
      if (!MemReq) begin
        rbeat  = 0;
        gapped = 1'b0;
        if (spur_en) begin
          MemValid = 1'b1;
          MemData  = 32'hDEAD_BEEF;
        end
      end else if (rbeat >= beat_limit) begin
        MemValid = 1'b0;
      end else if (rbeat > 0 && rbeat <= gap_budget && !gapped) begin
        gapped = 1'b1;
      end else begin
        MemValid = 1'b1;
        MemData  = mem_word(MemAddr + 32'(rbeat * 4));
      end
    end
  end

  // Monitor: scores every delivered instruction against the queue and every refill address.
  initial begin
    bit   prev_req;
    exp_t e;
    prev_req = 1'b0;
    forever begin
      @(negedge CLK);
      if (mon_en && !RST) begin
        if (MemReq && !prev_req) begin
          refill_cnt++;
          check("refill_addr", MemAddr, exp_addr);
        end
        if (Stall) begin
          check("stall_instr", Instr, NOP);
        end else if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_fetch: got %h at pc %h, expected no delivery", Instr, PC);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("instr@%h", e.pc), Instr, e.instr);
        end
      end
      prev_req = MemReq;
    end
  end

  // fl: 0 none, -1 Flush during the first lookup cycle, n>0 Flush in stall cycle n.
  task automatic fetch(input logic [31:0] pc, input logic [31:0] instr, input int exp_stall, input int fl);
    exp_t e;
    int   n;
    e.pc     = pc;
    e.instr  = instr;
    exp_q.push_back(e);
    exp_addr = pc & 32'hFFFF_FFF0;
    PC       = pc;
    Flush    = (fl < 0);
    n        = 0;
    forever begin
      @(negedge CLK);
      if (!Stall) break;
      n++;
      if (n == 1) check($sformatf("req_low_on_detect@%h", pc), {31'b0, MemReq}, 32'd0);
      if (n > 300) begin
        n_tests++;
        n_fail++;
        $display("FAIL fetch_timeout@%h: got stall > 300 cycles, expected %0d", pc, exp_stall);
        break;
      end
      Flush = (fl == n);
    end
    check($sformatf("stall_cycles@%h", pc), 32'(n), 32'(exp_stall));
    @(posedge CLK);
    #1;
    Flush = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    refill_cnt = 0;
    mon_en     = 1'b1;
    spur_en    = 1'b0;
    gap_budget = 0;
    beat_limit = 4;
    exp_addr   = 32'h0;
    RST        = 1'b1;
    PC         = 32'h0;
    Flush      = 1'b0;

    repeat (3) @(posedge CLK);
    #1;
    check("rst_stall", {31'b0, Stall}, 32'd1);
    check("rst_instr", Instr, NOP);
    check("rst_memreq", {31'b0, MemReq}, 32'd0);
    check("rst_memaddr", MemAddr, 32'h0);
    RST = 1'b0;

    // Cold fetch, then same-line hits.
    fetch(32'h0, 32'h0050_0093, 5, 0);
    fetch(32'h4, 32'h0060_0113, 0, 0);
    fetch(32'h8, 32'h0020_81B3, 0, 0);
    fetch(32'hC, 32'h0000_0013, 0, 0);
    check("refills_after_hits", 32'(refill_cnt), 32'd1);

    // Spurious MemValid while idle must not touch the array.
    spur_en = 1'b1;
    fetch(32'h4, 32'h0060_0113, 0, 0);
    fetch(32'h8, 32'h0020_81B3, 0, 0);
    spur_en = 1'b0;
    fetch(32'h0, 32'h0050_0093, 0, 0);
    fetch(32'hC, 32'h0000_0013, 0, 0);

    // Conflict eviction with two gap cycles, then the original line misses again.
    gap_budget = 2;
    fetch(32'h200, 32'hAAAA_0001, 7, 0);
    gap_budget = 0;
    fetch(32'h0, 32'h0050_0093, 5, 0);

    // Flush in idle: lookup in the flush cycle still hits, next one refetches.
    fetch(32'h4, 32'h0060_0113, 0, -1);
    fetch(32'h0, 32'h0050_0093, 5, 0);
    // Flush mid-refill: line stays invalid, a second refill of the same line follows.
    fetch(32'h200, 32'hAAAA_0001, 10, 3);
    fetch(32'h204, 32'hAAAA_0002, 0, 0);

    // Reset after three beats of a refill.
    exp_addr   = 32'h0;
    beat_limit = 3;
    PC         = 32'h0;
    repeat (6) @(negedge CLK);
    check("pre_rst_memreq", {31'b0, MemReq}, 32'd1);
    RST = 1'b1;
    #1;
    check("mid_rst_memreq", {31'b0, MemReq}, 32'd0);
    check("mid_rst_memaddr", MemAddr, 32'h0);
    check("mid_rst_stall", {31'b0, Stall}, 32'd1);
    check("mid_rst_instr", Instr, NOP);
    @(posedge CLK);
    #1;
    RST        = 1'b0;
    beat_limit = 4;
    fetch(32'h0, 32'h0050_0093, 5, 0);
    fetch(32'h8, 32'h0020_81B3, 0, 0);

    mon_en = 1'b0;
    check("pending_expectations", 32'(exp_q.size()), 32'd0);
    check("total_refills", 32'(refill_cnt), 32'd8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_cache_sys.md
Name: inst_cache_sys

Overview:
Direct-mapped, read-only instruction cache between the core's PC and a multi-cycle backing instruction memory. It replaces the single-cycle inst_mem path and mirrors the data-side cache system.
- Hits return the instruction combinationally in the same cycle.
- Misses raise Stall, refill one line by a beat-wise handshake, then resume.
- Stall is ORed with the data-side Stall at the PC.

Parameters:
- NUM_LINES, 32, number of cache lines (power of two).
- LINE_WORDS, 4, 32-bit words per line (power of two, ≥2).
- NOP_INSTR, 32'h00000013, instruction driven while stalled (addi x0,x0,0).

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  asynchronous, active-high reset.
- PC  input  32  byte fetch address from the PC register; bits[1:0] ignored.
- Flush  input  1  invalidate all lines (fence.i / self-modifying code).
- Instr  output  32  fetched instruction, or NOP_INSTR while Stall=1.
- Stall  output  1  high while the fetch at PC cannot complete this cycle.
- MemReq  output  1  line refill request, held high for the whole refill.
- MemAddr  output  32  byte address of the line base (PC with offset bits zeroed), stable while MemReq=1.
- MemValid  input  1  one returned word is valid this cycle.
- MemData  input  32  returned word, in ascending word order.

Behaviour:
Address fields (defaults):
- offset = PC[3:2] (log2 LINE_WORDS bits).
- index = PC[8:4] (log2 NUM_LINES bits).
- tag = remaining upper bits, PC[31:9].

Storage:
- valid[NUM_LINES] is flops, cleared by reset.
- Tag and data arrays are flops, not reset.

Lookup (combinational): hit = valid[index] && tag_array[index]==tag.

FSM states:
- IDLE: if hit, Instr = data[index][offset] and Stall=0. If miss, Stall=1, Instr=NOP_INSTR, and the next state is REFILL. The refill address is latched from PC at this edge.
- REFILL: MemReq=1, MemAddr=latched line base, Stall=1, Instr=NOP_INSTR.
  - Each cycle with MemValid=1 writes MemData into data[latched index][beat] and increments beat. Cycles with MemValid=0 are gaps and are waited out indefinitely.
  - On the beat==LINE_WORDS-1 acceptance edge: tag ← latched tag, valid ← 1 (unless flush_pend), beat ← 0, state → IDLE.

Latency:
- Miss penalty is 1 (miss-detect cycle) + LINE_WORDS + gap cycles.
- The cycle after return to IDLE, the lookup on the unchanged PC hits and Stall drops.

Handshake rules:
- MemReq is decoded from the registered state; it drops the cycle after the last beat.
- MemValid while MemReq=0 is ignored.
- MemData is sampled only when MemValid=1.

Flush:
- In IDLE: all valid bits clear at the edge. The lookup in the Flush cycle itself still uses the pre-flush valid bits.
- In REFILL: valid bits clear at the edge and flush_pend is set. The refill completes, but its line is not validated. flush_pend clears on return to IDLE, and the next lookup re-misses and refetches.

Reset (any time, including mid-refill):
- state=IDLE, beat=0, flush_pend=0, all valid bits=0.
- A partially filled line is discarded.

Reset output values (RST high):
- MemReq=0, MemAddr=0.
- Stall=1 while RST is held, because no line is valid.
- Instr=NOP_INSTR.

Other rules:
- A PC change during Stall is not permitted, because the PC register is frozen. The latched refill address governs regardless.
- Stall asserted by the data-side cache does not affect this block: a hit simply repeats.

Decomposition:
- Package inst_cache_pkg holds:
  - state encodings (IDLE, REFILL);
  - NOP_INSTR;
  - derived width constants OFF_W = log2(LINE_WORDS), IDX_W = log2(NUM_LINES), TAG_W = 30-OFF_W-IDX_W;
  - field-extract helper functions.
- One sub-module, inst_cache_array: valid/tag/data storage with a combinational read port (index, offset → word, tag, valid), a beat write port, a line-validate port and a flush-all port. The FSM, beat counter and refill-address latch stay in inst_cache_sys.

Test Plan:
1. Cold fetch: RST pulse, then PC=0x00000000.
   - Stall=1, Instr=0x00000013, MemReq=1 from the next cycle, MemAddr=0x00000000.
   - Return 0x00500093, 0x00600113, 0x002081B3, 0x00000013 on 4 consecutive cycles.
   - Cycle after the last beat: MemReq=0, Stall=0, Instr=0x00500093.
2. Same-line hits: PC=0x4, 0x8, 0xC after scenario 1 → Stall=0 every cycle, Instr=0x00600113, 0x002081B3, 0x00000013, MemReq never rises.
3. Conflict eviction: PC=0x00000200 (index 0, tag 1).
   - Miss, MemAddr=0x00000200, refill with 0xAAAA0001..4 using two MemValid=0 gap cycles between beats.
   - Stall lasts 1+4+2 cycles and returns 0xAAAA0001.
   - Then PC=0x0 misses again.
4. Flush: Flush=1 for one cycle in IDLE after scenario 1, then PC=0x0 → miss and full refill. Flush=1 mid-refill → line not validated, Stall stays high, a second refill of the same MemAddr follows.
5. Reset mid-refill: assert RST after beat 2.
   - MemReq=0 and state IDLE immediately (asynchronous).
   - After release, PC=0x0 misses and restarts from beat 0; the partial line is never hit.
6. Spurious MemValid=1 with MemData=0xDEADBEEF while IDLE → no array change; subsequent hit data unchanged.
